// File: rtl/axi_pkg.sv
// Shared AXI3 types: burst and response encodings, engine FSM states.
// Imported by the burst address generator and the slave memory top.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wfsm_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rfsm_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts, plus illegal wrap-length flag.
// Ports: addr/len/burst/size in; next_addr, wrap_err out. Purely combinational.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        len,
  input  logic [1:0]        burst,
  input  logic [2:0]        size,
  output logic [ADDR_W-1:0] next_addr,
  output logic              wrap_err
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] incr;

  always_comb begin
    step = ADDR_W'(1) << size;
    // wrap window spans (len+1) beats
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size)
           - ADDR_W'(1);
    incr = addr + step;
    wrap_err = (burst == WRAP) &&
               !(len inside {4'd1, 4'd3, 4'd7, 4'd15});
    next_addr = incr;
    unique case (1'b1)
      burst == FIXED: next_addr = addr;
      burst == WRAP:
        next_addr = (addr & ~mask) | (incr & mask);
      default: ;
    endcase
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI3 slave RAM: independent write/read engines, one burst each, SLVERR.
// Ports: aclk, aresetn, AW/W/B and AR/R channels (no lock/cache/prot).
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 8,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  =
    (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  function automatic logic bad_size(
    input logic [2:0] s);
    return s != 3'(LSB);
  endfunction

  function automatic logic oob(
    input logic [ADDR_W-1:0] a);
    return (a >> LSB) >= ADDR_W'(MEM_DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] widx(
    input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> LSB);
  endfunction

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // write engine
  wfsm_t             w_state_q, w_state_d;
  logic              awready_q, awready_d;
  logic [ID_W-1:0]   awid_q, awid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [3:0]        wlen_q, wlen_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [1:0]        wburst_q, wburst_d;
  logic [2:0]        wsize_q, wsize_d;
  logic              werr_q, werr_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              w_last_beat, w_beat_err;
  logic              mem_we;

  logic              w_idle;
  logic [ADDR_W-1:0] wg_next;
  logic              wg_wrap_err;

  assign w_idle = (w_state_q == W_IDLE);

  // idle: feed AW fields so the wrap check sees the new burst
  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wgen (
    .addr      (w_idle ? awaddr  : waddr_q),
    .len       (w_idle ? awlen   : wlen_q),
    .burst     (w_idle ? awburst : wburst_q),
    .size      (w_idle ? awsize  : wsize_q),
    .next_addr (wg_next),
    .wrap_err  (wg_wrap_err)
  );

  always_comb begin
    w_state_d   = w_state_q;
    awid_d      = awid_q;
    waddr_d     = waddr_q;
    wlen_d      = wlen_q;
    wcnt_d      = wcnt_q;
    wburst_d    = wburst_q;
    wsize_d     = wsize_q;
    werr_d      = werr_q;
    bresp_d     = bresp_q;
    w_last_beat = 1'b0;
    w_beat_err  = 1'b0;
    mem_we      = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          awid_d    = awid;
          waddr_d   = awaddr;
          wlen_d    = awlen;
          wburst_d  = awburst;
          wsize_d   = awsize;
          wcnt_d    = '0;
          werr_d    = bad_size(awsize) ||
                      (awburst == 2'b11) ||
                      wg_wrap_err;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          w_last_beat = (wcnt_q == wlen_q);
          w_beat_err  = werr_q || oob(waddr_q) ||
                        (wid != awid_q) ||
                        (wlast != w_last_beat);
          mem_we  = !w_beat_err;
          werr_d  = werr_q | w_beat_err;
          waddr_d = wg_next;
          wcnt_d  = wcnt_q + 4'd1;
          if (w_last_beat) begin
            w_state_d = W_RESP;
            bresp_d   = werr_d ? SLVERR : OKAY;
          end
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      awid_q    <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wburst_q  <= '0;
      wsize_q   <= '0;
      werr_q    <= 1'b0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wburst_q  <= wburst_d;
      wsize_q   <= wsize_d;
      werr_q    <= werr_d;
      bresp_q   <= bresp_d;
    end
  end

  // contents survive reset
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i])
          mem[widx(waddr_q)][i*8 +: 8] <=
            wdata[i*8 +: 8];
      end
    end
  end

  // read engine
  rfsm_t             r_state_q, r_state_d;
  logic              arready_q, arready_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [3:0]        rlen_q, rlen_d;
  logic [3:0]        rcnt_q, rcnt_d;
  logic [1:0]        rburst_q, rburst_d;
  logic [2:0]        rsize_q, rsize_d;
  logic              rerr_q, rerr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic              rvalid_q, rvalid_d;
  logic              r_load, r_beat_err;
  logic [ADDR_W-1:0] r_beat_addr;

  logic              r_idle;
  logic [ADDR_W-1:0] rg_next;
  logic              rg_wrap_err;

  assign r_idle = (r_state_q == R_IDLE);

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rgen (
    .addr      (r_idle ? araddr  : raddr_q),
    .len       (r_idle ? arlen   : rlen_q),
    .burst     (r_idle ? arburst : rburst_q),
    .size      (r_idle ? arsize  : rsize_q),
    .next_addr (rg_next),
    .wrap_err  (rg_wrap_err)
  );

  always_comb begin
    r_state_d   = r_state_q;
    rid_d       = rid_q;
    raddr_d     = raddr_q;
    rlen_d      = rlen_q;
    rcnt_d      = rcnt_q;
    rburst_d    = rburst_q;
    rsize_d     = rsize_q;
    rerr_d      = rerr_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    rvalid_d    = rvalid_q;
    r_load      = 1'b0;
    r_beat_err  = 1'b0;
    r_beat_addr = raddr_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          rid_d       = arid;
          rlen_d      = arlen;
          rburst_d    = arburst;
          rsize_d     = arsize;
          rcnt_d      = '0;
          rerr_d      = bad_size(arsize) ||
                        (arburst == 2'b11) ||
                        rg_wrap_err;
          r_beat_addr = araddr;
          r_load      = 1'b1;
          r_state_d   = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_beat_addr = rg_next;
            rcnt_d      = rcnt_q + 4'd1;
            r_load      = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // memory sampled before this edge's write: reads see old data
    if (r_load) begin
      r_beat_err = rerr_d || oob(r_beat_addr);
      rerr_d     = r_beat_err;
      raddr_d    = r_beat_addr;
      rdata_d    = r_beat_err ? '0
                              : mem[widx(r_beat_addr)];
      rresp_d    = r_beat_err ? SLVERR : OKAY;
      rlast_d    = (rcnt_d == rlen_d);
      rvalid_d   = 1'b1;
    end
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rburst_q  <= '0;
      rsize_q   <= '0;
      rerr_q    <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rburst_q  <= rburst_d;
      rsize_q   <= rsize_d;
      rerr_q    <= rerr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign awready = awready_q;
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bid     = awid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem with B/R scoreboards.
// Expected responses are queued at stimulus time and popped on output.
module tb_axi_slave_mem;
  import axi_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  awid, wid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  axi_slave_mem dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_r_t;

  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } exp_b_t;

  exp_r_t      rq[$];
  exp_b_t      bq[$];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tchk(input string tag,
                      input logic ok);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed timeout expected handshake",
             tag);
    end
  endtask

  task automatic set_w4(input logic [31:0] a, b, c, d);
    wd[0] = a; wd[1] = b; wd[2] = c; wd[3] = d;
    for (int i = 0; i < 16; i++) ws[i] = 4'hF;
  endtask

  task automatic push_r(input logic [31:0] d,
                        input logic [1:0] r,
                        input logic l);
    exp_r_t e;
    e.data = d; e.resp = r; e.last = l;
    rq.push_back(e);
  endtask

  task automatic wr(input logic [7:0] id,
                    input logic [31:0] addr,
                    input logic [3:0] len,
                    input logic [1:0] burst,
                    input logic [1:0] exp,
                    input logic [7:0] wx,
                    input int hold);
    exp_b_t e;
    int n;
    e.id = id; e.resp = exp;
    bq.push_back(e);
    @(posedge aclk); #1;
    awid = id; awaddr = addr; awlen = len;
    awburst = burst; awsize = 3'd2; awvalid = 1'b1;
    @(negedge aclk); n = 0;
    while (!awready && n < 50) begin
      @(negedge aclk); n++;
    end
    tchk("aw_hs", awready);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wid = id ^ wx; wdata = wd[i]; wstrb = ws[i];
      wlast = (i == int'(len)); wvalid = 1'b1;
      @(negedge aclk); n = 0;
      while (!wready && n < 50) begin
        @(negedge aclk); n++;
      end
      tchk("w_hs", wready);
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge aclk); n = 0;
    while (!bvalid && n < 50) begin
      @(negedge aclk); n++;
    end
    tchk("b_wait", bvalid);
    e = bq.pop_front();
    repeat (hold) begin
      chk("b_hold", {bvalid, bid, bresp},
          {1'b1, e.id, e.resp});
      @(negedge aclk);
    end
    bready = 1'b1;
    chk("bid", bid, e.id);
    chk("bresp", bresp, e.resp);
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic ar_hs(input logic [7:0] id,
                       input logic [31:0] addr,
                       input logic [3:0] len,
                       input logic [1:0] burst);
    int n;
    @(posedge aclk); #1;
    arid = id; araddr = addr; arlen = len;
    arburst = burst; arsize = 3'd2; arvalid = 1'b1;
    @(negedge aclk); n = 0;
    while (!arready && n < 50) begin
      @(negedge aclk); n++;
    end
    tchk("ar_hs", arready);
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] id,
                    input logic [31:0] addr,
                    input logic [3:0] len,
                    input logic [1:0] burst,
                    input int hold);
    exp_r_t e;
    int n;
    bit first;
    first = 1'b1;
    ar_hs(id, addr, len, burst);
    rready = (hold == 0);
    while (rq.size() > 0) begin
      @(negedge aclk); n = 0;
      while (!rvalid && n < 50) begin
        @(negedge aclk); n++;
      end
      tchk("r_wait", rvalid);
      if (!rvalid) begin
        rq.delete();
        break;
      end
      e = rq[0];
      if (first && hold > 0) begin
        repeat (hold) begin
          chk("r_hold", {rvalid, rid, rdata, rresp, rlast},
              {1'b1, id, e.data, e.resp, e.last});
          @(negedge aclk);
        end
        rready = 1'b1;
      end
      first = 1'b0;
      e = rq.pop_front();
      chk("rid", rid, id);
      chk("rdata", rdata, e.data);
      chk("rresp", rresp, e.resp);
      chk("rlast", rlast, e.last);
      @(posedge aclk); #1;
    end
    rready = 1'b0;
  endtask

  initial begin
    int n;
    aresetn = 1'b0;
    {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
    {wid, wdata, wstrb, wlast, wvalid, bready} = '0;
    {arid, araddr, arlen, arsize, arburst, arvalid} = '0;
    rready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_out", {awready, wready, bvalid, arready,
                    rvalid, rlast, bid, rid, bresp,
                    rresp, rdata}, 64'd0);
    #2 aresetn = 1'b1;
    #1 chk("rdy_pre_edge", {awready, arready}, 2'b00);
    @(negedge aclk);
    chk("rdy_rise", {awready, arready}, 2'b11);

    set_w4(32'h11, 32'h22, 32'h33, 32'h44);
    wr(8'h01, 32'h10, 4'd3, INCR, OKAY, 8'h0, 0);
    push_r(32'h11, OKAY, 1'b0);
    push_r(32'h22, OKAY, 1'b0);
    push_r(32'h33, OKAY, 1'b0);
    push_r(32'h44, OKAY, 1'b1);
    rd(8'h02, 32'h10, 4'd3, INCR, 0);

    set_w4(32'hFFFF_FFFF, 0, 0, 0);
    wr(8'h03, 32'h20, 4'd0, INCR, OKAY, 8'h0, 0);
    wd[0] = 32'h0; ws[0] = 4'b0101;
    wr(8'h03, 32'h20, 4'd0, INCR, OKAY, 8'h0, 0);
    push_r(32'hFF00_FF00, OKAY, 1'b1);
    rd(8'h04, 32'h20, 4'd0, INCR, 0);

    set_w4(32'hA, 32'hB, 32'hC, 32'hD);
    wr(8'h05, 32'h38, 4'd3, WRAP, OKAY, 8'h0, 0);
    push_r(32'hC, OKAY, 1'b0);
    push_r(32'hD, OKAY, 1'b0);
    push_r(32'hA, OKAY, 1'b0);
    push_r(32'hB, OKAY, 1'b1);
    rd(8'h06, 32'h30, 4'd3, INCR, 0);
    push_r(32'hA, OKAY, 1'b0);
    push_r(32'hB, OKAY, 1'b0);
    push_r(32'hC, OKAY, 1'b0);
    push_r(32'hD, OKAY, 1'b1);
    rd(8'h07, 32'h38, 4'd3, WRAP, 0);

    set_w4(32'h1, 32'h2, 32'h3, 32'h4);
    wr(8'h08, 32'h40, 4'd3, FIXED, OKAY, 8'h0, 0);
    push_r(32'h4, OKAY, 1'b1);
    rd(8'h09, 32'h40, 4'd0, INCR, 0);

    set_w4(32'h5A5A_5A5A, 0, 0, 0);
    wr(8'h0A, 32'h0, 4'd0, INCR, OKAY, 8'h0, 0);
    set_w4(32'hDEAD_0001, 32'hDEAD_0002, 0, 0);
    wr(8'h0B, 32'h1000, 4'd1, INCR, SLVERR, 8'h0, 0);
    push_r(32'h0, SLVERR, 1'b0);
    push_r(32'h0, SLVERR, 1'b1);
    rd(8'h0C, 32'h1000, 4'd1, INCR, 0);
    push_r(32'h5A5A_5A5A, OKAY, 1'b1);
    rd(8'h0D, 32'h0, 4'd0, INCR, 0);

    set_w4(32'hCAFE_F00D, 0, 0, 0);
    wr(8'h0E, 32'h50, 4'd0, INCR, OKAY, 8'h0, 0);
    set_w4(32'h1234_5678, 0, 0, 0);
    wr(8'h0F, 32'h50, 4'd0, INCR, SLVERR, 8'h01, 0);
    push_r(32'hCAFE_F00D, OKAY, 1'b1);
    rd(8'h10, 32'h50, 4'd0, INCR, 0);
    push_r(32'h0, SLVERR, 1'b0);
    push_r(32'h0, SLVERR, 1'b0);
    push_r(32'h0, SLVERR, 1'b1);
    rd(8'h11, 32'h30, 4'd2, WRAP, 0);

    set_w4(32'h600D, 0, 0, 0);
    wr(8'h12, 32'h60, 4'd0, INCR, OKAY, 8'h0, 5);
    push_r(32'h11, OKAY, 1'b0);
    push_r(32'h22, OKAY, 1'b0);
    push_r(32'h33, OKAY, 1'b0);
    push_r(32'h44, OKAY, 1'b1);
    rd(8'h13, 32'h10, 4'd3, INCR, 5);

    ar_hs(8'h14, 32'h10, 4'd3, INCR);
    rready = 1'b1;
    @(negedge aclk); n = 0;
    while (!rvalid && n < 50) begin
      @(negedge aclk); n++;
    end
    tchk("rst_r_wait", rvalid);
    chk("rst_beat0", rdata, 32'h11);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("rst_beat1", {rvalid, rdata}, {1'b1, 32'h22});
    aresetn = 1'b0;
    #1 chk("rst_mid", {awready, wready, bvalid, arready,
                      rvalid, rlast, rdata}, 64'd0);
    rready = 1'b0;
    @(negedge aclk);
    #2 aresetn = 1'b1;
    #1 chk("rst_rel_pre", arready, 1'b0);
    @(negedge aclk);
    chk("rst_rel_post", arready, 1'b1);
    push_r(32'h22, OKAY, 1'b1);
    rd(8'h15, 32'h14, 4'd0, INCR, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
